// File: rtl/seq_shift_add_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Helpers work on a wide fixed vector; callers narrow the result with a width cast.
package seq_shift_add_mult_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement magnitude when is_neg is set, otherwise pass-through.
  function automatic logic [MAX_W-1:0] abs_n(input logic [MAX_W-1:0] x, input logic is_neg);
    return is_neg ? (~x + MAX_W'(1)) : x;
  endfunction

  function automatic logic [MAX_W-1:0] neg_2n(input logic [MAX_W-1:0] x);
    return ~x + MAX_W'(1);
  endfunction

endpackage

// File: rtl/seq_shift_add_mult.sv
// Multi-cycle shift-add multiplier: one multiplier bit per clock, signed/unsigned,
// valid/ready on both sides and a synchronous abort. Supports N up to 32.
module seq_shift_add_mult
  import seq_shift_add_mult_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stop,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);

  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned PW    = 2 * N;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_p;
  logic [N-1:0]     r_mult;
  logic             r_neg;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_last;
  logic [N-1:0]     w_abs_a;
  logic [N-1:0]     w_abs_b;
  logic [PW-1:0]    w_acc_sum;
  logic [PW-1:0]    w_acc_neg;

  // Magnitudes are taken at accept time so the core loop is always unsigned.
  assign w_abs_a   = N'(abs_n(MAX_W'(a), signed_mode & a[N-1]));
  assign w_abs_b   = N'(abs_n(MAX_W'(b), signed_mode & b[N-1]));
  assign w_acc_sum = r_acc + (r_mult[0] ? r_mcand : '0);
  assign w_acc_neg = PW'(neg_2n(MAX_W'(w_acc_sum)));

  assign in_ready  = (r_state == IDLE) && !stop;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_state == BUSY) && (r_cnt == CNT_W'(N - 1));

  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == BUSY);
  assign p         = r_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; stop overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (stop) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_nxt = BUSY;
        BUSY:    if (w_last) w_state_nxt = DONE;
        DONE:    if (out_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_mult  <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else if (w_accept) begin
      r_mcand <= PW'(w_abs_a);
      r_mult  <= w_abs_b;
      r_neg   <= signed_mode & (a[N-1] ^ b[N-1]);
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if ((r_state == BUSY) && !stop) begin
      r_acc   <= w_acc_sum;
      r_mcand <= r_mcand << 1;
      r_mult  <= r_mult >> 1;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) r_p <= r_neg ? w_acc_neg : w_acc_sum;
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult: directed literal cases plus random traffic
// compared every cycle against a transaction-level model.
module tb_seq_shift_add_mult;

  localparam int unsigned N  = 8;
  localparam int unsigned PW = 2 * N;

  logic          clk;
  logic          rst;
  logic          stop;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          signed_mode;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] p;
  logic          busy;

  seq_shift_add_mult #(.N(N)) dut (
    .clk(clk), .rst(rst), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Model: cycles of work left, whether a result is being offered, and its value.
  int            m_left;
  logic          m_valid;
  logic [PW-1:0] m_p;
  logic [PW-1:0] m_pending;

  function automatic logic [PW-1:0] ref_prod(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic sm);
    longint sx;
    longint sy;
    sx = sm ? longint'($signed(x)) : longint'(x);
    sy = sm ? longint'($signed(y)) : longint'(y);
    return PW'(sx * sy);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left  = 0;
    m_valid = 1'b0;
    m_p     = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_edge();
    if (stop) begin
      m_left  = 0;
      m_valid = 1'b0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1'b1;
        m_p     = m_pending;
      end
    end else if (in_valid) begin
      m_left    = N;
      m_pending = ref_prod(a, b, signed_mode);
    end
  endtask

  task automatic compare();
    chk("in_ready", 64'(in_ready), 64'((m_left == 0) && !m_valid && !stop));
    chk("busy", 64'(busy), 64'(m_left > 0));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("p", 64'(p), 64'(m_p));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  // Issue one operation from IDLE, measure latency and pin the product to a literal.
  task automatic run_op(input logic [N-1:0] xa, input logic [N-1:0] xb, input logic sm,
                        input logic [PW-1:0] exp_p, input string tag);
    int lat;
    a = xa; b = xb; signed_mode = sm; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    a = N'($urandom); b = N'($urandom); signed_mode = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      cycle();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(N));
    chk({tag, "_p"}, 64'(p), 64'(exp_p));
    if (out_ready) begin
      cycle();
      chk({tag, "_idle"}, 64'(in_ready), 64'(1));
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; stop = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; signed_mode = 1'b0;
    model_reset();
    #2;
    compare();
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_p", 64'(p), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op(8'd13, 8'd11, 1'b0, 16'd143, "u13x11");
    run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "umax");
    run_op(8'h00, 8'hA5, 1'b0, 16'h0000, "uzero");
    run_op(8'hFD, 8'd7, 1'b1, 16'hFFEB, "sneg3x7");
    run_op(8'h80, 8'h80, 1'b1, 16'h4000, "smin2");
    run_op(8'h80, 8'h01, 1'b1, 16'hFF80, "sminx1");

    // Backpressure: result held while the consumer stalls; inputs ignored.
    out_ready = 1'b0;
    run_op(8'd9, 8'd12, 1'b0, 16'd108, "bp");
    repeat (5) begin
      in_valid = 1'($urandom);
      a = N'($urandom); b = N'($urandom);
      cycle();
      chk("bp_hold_p", 64'(p), 64'(108));
      chk("bp_hold_valid", 64'(out_valid), 64'(1));
      chk("bp_no_ready", 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("bp_release_valid", 64'(out_valid), 64'(0));
    chk("bp_release_ready", 64'(in_ready), 64'(1));

    // Abort on the 4th BUSY cycle.
    a = 8'd77; b = 8'd3; signed_mode = 1'b0; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    stop = 1'b1;
    cycle();
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_valid", 64'(out_valid), 64'(0));
    chk("abort_ready_forced", 64'(in_ready), 64'(0));
    stop = 1'b0;
    repeat (10) cycle();
    run_op(8'd5, 8'd6, 1'b0, 16'd30, "post_abort");

    // Asynchronous reset between clock edges while BUSY.
    a = 8'd100; b = 8'd100; signed_mode = 1'b0; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_p", 64'(p), 64'(0));
    chk("arst_ready", 64'(in_ready), 64'(1));
    model_reset();
    #1 rst = 1'b0;
    run_op(8'd2, 8'd2, 1'b1, 16'd4, "post_rst");

    // Random traffic against the model.
    repeat (600) begin
      in_valid    = 1'($urandom_range(0, 1));
      out_ready   = ($urandom_range(0, 3) != 0);
      stop        = ($urandom_range(0, 39) == 0);
      a           = N'($urandom);
      b           = N'($urandom);
      signed_mode = 1'($urandom);
      cycle();
    end
    stop = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (N + 3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
